// File: rtl/uart_rx_sink_if.sv
// Byte stream leaving the UART receiver FIFO.
// Master is the receiver, slave is the consumer.
interface uart_rx_sink_if;
  logic       valid;
  logic       ready;
  logic [7:0] payload;

  modport master (
    output valid,
    output payload,
    input  ready
  );

  modport slave (
    input  valid,
    input  payload,
    output ready
  );
endinterface

// File: rtl/uart_rx_sink.sv
// 8N1 UART receiver with output FIFO, CTS flow control,
// frame/overflow pulses and error/byte counters.
module uart_rx_sink #(
  parameter int CLOCK_HZ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           io_clock,
  input  logic           io_reset,
  input  logic           io_rxd,
  output logic           io_ctsN,
  uart_rx_sink_if.master io_data,
  output logic           io_frameError,
  output logic           io_overflow,
  output logic [7:0]     io_errorCount,
  output logic [15:0]    io_byteCount
);
  localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(HALF_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] TWO_C       = CW'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic          meta_q, sync_q, prev_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q, count_d;
  logic          cts_q, cts_d;
  logic          ferr_q, ovf_q;
  logic [7:0]    ecnt_q, ecnt_d;
  logic [15:0]   bcnt_q;

  logic          fall, timer_zero;
  logic          push_req, ferr_set;
  logic          pop, full, push_ok, drop;
  logic [8:0]    esum;

  // Idle-high reset values make a line held low at release
  // look like a start edge.
  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= io_rxd;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall       = prev_q & ~sync_q;
  assign timer_zero = (timer_q == '0);

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    if (!timer_zero)
      timer_d = timer_q - 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          timer_d = HALF_RELOAD;
        end
      end
      S_START: begin
        if (timer_zero) begin
          if (!sync_q) begin
            state_d   = S_DATA;
            timer_d   = BIT_RELOAD;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (timer_zero) begin
          shift_d   = {sync_q, shift_q[7:1]};
          timer_d   = BIT_RELOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7)
            state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_zero)
          state_d = sync_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (sync_q)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push_req = 1'b0;
    ferr_set = 1'b0;
    if (state_q == S_STOP && timer_zero) begin
      push_req = sync_q;
      ferr_set = ~sync_q;
    end
  end

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign pop     = (count_q != '0) && io_data.ready;
  assign full    = (count_q == DEPTH_C);
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;
  assign count_d = count_q + CW'(push_ok) - CW'(pop);
  assign cts_d   = (DEPTH_C - count_d) < TWO_C;

  assign esum   = {1'b0, ecnt_q} + 9'(ferr_set) + 9'(drop);
  assign ecnt_d = esum[8] ? 8'hFF : esum[7:0];

  always_ff @(posedge io_clock) begin
    if (push_ok)
      mem_q[wr_q] <= shift_q;
  end

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      cts_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ecnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      if (push_ok)
        wr_q <= wr_q + 1'b1;
      if (pop)
        rd_q <= rd_q + 1'b1;
      count_q <= count_d;
      cts_q   <= cts_d;
      ferr_q  <= ferr_set;
      ovf_q   <= drop;
      ecnt_q  <= ecnt_d;
      bcnt_q  <= bcnt_q + 16'(push_ok);
    end
  end

  assign io_data.valid   = (count_q != '0);
  assign io_data.payload = io_data.valid ? mem_q[rd_q] : 8'h00;
  assign io_ctsN         = cts_q;
  assign io_frameError   = ferr_q;
  assign io_overflow     = ovf_q;
  assign io_errorCount   = ecnt_q;
  assign io_byteCount    = bcnt_q;
endmodule

// File: tb/tb_uart_rx_sink.sv
// Bench for uart_rx_sink: vector table, corner sequences
// and a randomized frame stream against a byte-queue model.
module tb_uart_rx_sink;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 62500;
  localparam int C      = CLK_HZ / BAUD;
  localparam int H      = C / 2;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         exp_byte;
    bit         exp_ferr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic        ctsN, ferr, ovf;
  logic [7:0]  ecnt;
  logic [15:0] bcnt;
  logic        rdy_fix = 1'b0;
  logic        rdy_rnd = 1'b0;
  logic        rnd_mode = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ferr = 0;
  int n_ovf = 0;
  logic [7:0] got[$];

  uart_rx_sink_if dif();
  assign dif.ready = rnd_mode ? rdy_rnd : rdy_fix;

  always #5 clk = ~clk;

  uart_rx_sink #(
    .CLOCK_HZ  (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(4)
  ) dut (
    .io_clock     (clk),
    .io_reset     (rst_n),
    .io_rxd       (rxd),
    .io_ctsN      (ctsN),
    .io_data      (dif),
    .io_frameError(ferr),
    .io_overflow  (ovf),
    .io_errorCount(ecnt),
    .io_byteCount (bcnt)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (dif.valid && dif.ready)
        got.push_back(dif.payload);
      if (ferr)
        n_ferr++;
      if (ovf)
        n_ovf++;
    end
  end

  always @(posedge clk) begin
    #1 rdy_rnd = ($urandom_range(0, 1) == 1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] d);
    rxd = 1'b0;
    cyc(C);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      cyc(C);
    end
  endtask

  // Bad stop bits are held low for two bit times, then idle.
  task automatic send(input logic [7:0] d, input bit stop_ok);
    send_bits(d);
    rxd = stop_ok;
    cyc(C);
    if (!stop_ok) begin
      cyc(C);
      rxd = 1'b1;
      cyc(C);
    end
    rxd = 1'b1;
  endtask

  vec_t       vt[$];
  logic [7:0] exp_q[$];
  int b0, e0, f0, o0, g0, nerr;
  logic [7:0] d;
  bit ok;

  initial begin
    vt.push_back('{8'h55, 1'b1, 1'b1, 1'b0});
    vt.push_back('{8'h3C, 1'b0, 1'b0, 1'b1});
    vt.push_back('{8'h81, 1'b1, 1'b1, 1'b0});
    vt.push_back('{8'h00, 1'b1, 1'b1, 1'b0});
    vt.push_back('{8'hFF, 1'b0, 1'b0, 1'b1});
    vt.push_back('{8'hFF, 1'b1, 1'b1, 1'b0});

    cyc(3);
    chk("rst_valid", 32'(dif.valid), 0);
    chk("rst_payload", 32'(dif.payload), 0);
    chk("rst_cts", 32'(ctsN), 0);
    chk("rst_pulses", 32'({ferr, ovf}), 0);
    chk("rst_ecnt", 32'(ecnt), 0);
    chk("rst_bcnt", 32'(bcnt), 0);
    rst_n = 1'b1;
    cyc(2 * C);

    rdy_fix = 1'b1;
    foreach (vt[i]) begin
      b0 = int'(bcnt);
      e0 = int'(ecnt);
      f0 = n_ferr;
      g0 = got.size();
      send(vt[i].data, vt[i].stop_ok);
      cyc(C);
      chk($sformatf("vec%0d_xfers", i), 32'(got.size() - g0),
          32'(vt[i].exp_byte));
      if (vt[i].exp_byte && got.size() > 0)
        chk($sformatf("vec%0d_data", i), 32'(got[$]),
            32'(vt[i].data));
      chk($sformatf("vec%0d_bcnt", i), 32'(int'(bcnt) - b0),
          32'(vt[i].exp_byte));
      chk($sformatf("vec%0d_ecnt", i), 32'(int'(ecnt) - e0),
          32'(vt[i].exp_ferr));
      chk($sformatf("vec%0d_ferr", i), 32'(n_ferr - f0),
          32'(vt[i].exp_ferr));
    end
    chk("vec_no_ovf", 32'(n_ovf), 0);

    // False start: low for less than half a bit.
    g0 = got.size();
    e0 = int'(ecnt);
    rxd = 1'b0;
    cyc(H - 4);
    rxd = 1'b1;
    cyc(2 * C);
    chk("false_xfers", 32'(got.size() - g0), 0);
    chk("false_ecnt", 32'(int'(ecnt) - e0), 0);
    send(8'hA3, 1'b1);
    cyc(C);
    chk("false_next_n", 32'(got.size() - g0), 1);
    chk("false_next_d", 32'(got[$]), 32'h A3);

    // Overflow and flow control.
    got.delete();
    rdy_fix = 1'b0;
    b0 = int'(bcnt);
    e0 = int'(ecnt);
    o0 = n_ovf;
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    chk("cts_after2", 32'(ctsN), 0);
    send(8'h03, 1'b1);
    chk("cts_after3", 32'(ctsN), 1);
    send(8'h04, 1'b1);
    send(8'h05, 1'b1);
    cyc(C);
    chk("ovf_pulses", 32'(n_ovf - o0), 1);
    chk("ovf_ecnt", 32'(int'(ecnt) - e0), 1);
    chk("ovf_bcnt", 32'(int'(bcnt) - b0), 4);
    chk("ovf_cts_full", 32'(ctsN), 1);
    rdy_fix = 1'b1;
    cyc(10);
    chk("ovf_drain_n", 32'(got.size()), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("ovf_drain%0d", i), 32'(got[i]), 32'(i + 1));
    chk("ovf_cts_back", 32'(ctsN), 0);

    // Reset during bit 4 of 0xF0.
    rxd = 1'b0;
    cyc(C);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b0;
      cyc(C);
    end
    rxd = 1'b1;
    cyc(H);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(dif.valid), 0);
    chk("mrst_cts", 32'(ctsN), 0);
    chk("mrst_ecnt", 32'(ecnt), 0);
    chk("mrst_bcnt", 32'(bcnt), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2 * C);
    g0 = got.size();
    send(8'h5A, 1'b1);
    cyc(C);
    chk("mrst_next_bcnt", 32'(bcnt), 1);
    chk("mrst_next_n", 32'(got.size() - g0), 1);
    chk("mrst_next_d", 32'(got[$]), 32'h5A);

    // Push and pop on the same edge while full.
    got.delete();
    rdy_fix = 1'b0;
    b0 = int'(bcnt);
    o0 = n_ovf;
    for (int k = 0; k < 4; k++)
      send(8'(8'h10 + k), 1'b1);
    send_bits(8'h14);
    rxd = 1'b1;
    cyc(10);
    rdy_fix = 1'b1;
    cyc(1);
    rdy_fix = 1'b0;
    cyc(C);
    chk("pp_no_ovf", 32'(n_ovf - o0), 0);
    chk("pp_bcnt", 32'(int'(bcnt) - b0), 5);
    chk("pp_one_pop", 32'(got.size()), 1);
    rdy_fix = 1'b1;
    cyc(10);
    chk("pp_drain_n", 32'(got.size()), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk($sformatf("pp_drain%0d", i), 32'(got[i]), 32'(8'h10 + i));

    // Random frames, random consumer stalls.
    got.delete();
    exp_q.delete();
    nerr = 0;
    b0 = int'(bcnt);
    e0 = int'(ecnt);
    o0 = n_ovf;
    rnd_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send(d, ok);
      if (ok)
        exp_q.push_back(d);
      else
        nerr++;
      cyc($urandom_range(0, 20));
    end
    rnd_mode = 1'b0;
    rdy_fix = 1'b1;
    cyc(20);
    chk("rnd_count", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("rnd_byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
    chk("rnd_bcnt", 32'(int'(bcnt) - b0), 32'(exp_q.size()));
    chk("rnd_ecnt", 32'(int'(ecnt) - e0), 32'(nerr));
    chk("rnd_no_ovf", 32'(n_ovf - o0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
